// File: rtl/fifo_flags_behav.sv
// Single-clock synchronous FIFO with full-depth capacity, optional first-word-fall-through
// output stage, occupancy count, programmable almost flags and sticky error flags.
module fifo_flags_behav #(
  parameter int B     = 16,
  parameter int N     = 16,
  parameter bit FWFT  = 1'b0,
  parameter int AF_TH = N - 2,
  parameter int AE_TH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [B-1:0]         din,
  input  logic                 rd_en,
  output logic [B-1:0]         dout,
  output logic                 valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [$clog2(N):0]   count,
  input  logic                 err_clr,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] AF_C = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C = CW'(AE_TH);

  logic [B-1:0]  mem [N];

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] mem_cnt;
  logic [B-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          full_int, empty_int;
  logic          wr_acc, rd_acc, load;

  always_comb begin
    mem_cnt   = wptr_q - rptr_q;
    full_int  = (count_q == N_C);
    empty_int = FWFT ? !valid_q : (count_q == '0);
    wr_acc    = wr_en && !full_int;
    rd_acc    = 1'b0;
    load      = 1'b0;
    if (FWFT) begin
      // refill the head register whenever it is vacant or being popped
      rd_acc = rd_en && valid_q;
      load   = (!valid_q || rd_acc) && (mem_cnt != '0);
    end else begin
      rd_acc = rd_en && !empty_int;
      load   = rd_acc;
    end

    wptr_d  = wptr_q + CW'(wr_acc);
    rptr_d  = rptr_q + CW'(load);
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    dout_d  = load ? mem[rptr_q[AW-1:0]] : dout_q;

    if (FWFT) valid_d = load || (valid_q && !rd_acc);
    else      valid_d = rd_acc;

    // a fresh error event wins over a coincident clear
    ovf_d = (ovf_q && !err_clr) || (wr_en && full_int);
    unf_d = (unf_q && !err_clr) || (rd_en && empty_int);
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign full         = full_int;
  assign empty        = empty_int;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flags_behav.sv
// Bench for fifo_flags_behav: standard and FWFT instances share stimulus and are checked
// every cycle against queue-based models, plus hand-computed literal expectations.
module tb_fifo_flags_behav;

  localparam int N  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] din = '0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;

  logic [15:0] s_dout, f_dout;
  logic        s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic        f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]  s_count, f_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_flags_behav #(.B(16), .N(N), .FWFT(1'b0), .AF_TH(AF), .AE_TH(AE)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_flags_behav #(.B(16), .N(N), .FWFT(1'b1), .AF_TH(AF), .AE_TH(AE)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Models: a queue holds every stored word; FWFT head is visible once it was stored
  // before the edge and survived the pop.
  logic [15:0] sq[$];
  logic [15:0] fq[$];
  logic [15:0] m_s_dout, m_f_dout;
  bit m_s_valid, m_s_ovf, m_s_unf, m_f_valid, m_f_ovf, m_f_unf;
  int n;
  bit wa, ra;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sq.delete(); fq.delete();
      m_s_dout = '0; m_f_dout = '0;
      m_s_valid = 0; m_s_ovf = 0; m_s_unf = 0;
      m_f_valid = 0; m_f_ovf = 0; m_f_unf = 0;
    end else begin
      n  = sq.size();
      wa = wr_en && (n < N);
      ra = rd_en && (n > 0);
      m_s_ovf   = (m_s_ovf && !err_clr) || (wr_en && n == N);
      m_s_unf   = (m_s_unf && !err_clr) || (rd_en && n == 0);
      m_s_valid = ra;
      if (ra) m_s_dout = sq.pop_front();
      if (wa) sq.push_back(din);

      n  = fq.size();
      wa = wr_en && (n < N);
      ra = rd_en && m_f_valid;
      m_f_ovf = (m_f_ovf && !err_clr) || (wr_en && n == N);
      m_f_unf = (m_f_unf && !err_clr) || (rd_en && !m_f_valid);
      if (ra) void'(fq.pop_front());
      m_f_valid = (fq.size() > 0);
      if (m_f_valid) m_f_dout = fq[0];
      if (wa) fq.push_back(din);
    end
  end

  always @(negedge clk) begin
    chk("s_count", s_count, sq.size());
    chk("s_full", s_full, sq.size() == N);
    chk("s_empty", s_empty, sq.size() == 0);
    chk("s_almost_full", s_af, sq.size() >= AF);
    chk("s_almost_empty", s_ae, sq.size() <= AE);
    chk("s_valid", s_valid, m_s_valid);
    chk("s_dout", s_dout, m_s_dout);
    chk("s_overflow", s_ovf, m_s_ovf);
    chk("s_underflow", s_unf, m_s_unf);
    chk("f_count", f_count, fq.size());
    chk("f_full", f_full, fq.size() == N);
    chk("f_empty", f_empty, !m_f_valid);
    chk("f_almost_full", f_af, fq.size() >= AF);
    chk("f_almost_empty", f_ae, fq.size() <= AE);
    chk("f_valid", f_valid, m_f_valid);
    if (m_f_valid) chk("f_dout", f_dout, m_f_dout);
    chk("f_overflow", f_ovf, m_f_ovf);
    chk("f_underflow", f_unf, m_f_unf);
  end

  // Apply inputs for one edge, return 1 time unit after it.
  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic c);
    wr_en = w; din = d; rd_en = r; err_clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic reset_pulse();
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_d;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_almost_empty", s_ae, 1);
    chk("rst_dout", s_dout, 0);

    // fill / overflow / drain / underflow in standard mode
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    chk("fill_count", s_count, 16);
    chk("fill_full", s_full, 1);
    chk("fill_fwft_count", f_count, 16);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("ovf_flag", s_ovf, 1);
    chk("ovf_count", s_count, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("drain_valid", s_valid, 1);
      chk("drain_dout", s_dout, i);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("drained_empty", s_empty, 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("unf_flag", s_unf, 1);
    chk("unf_valid", s_valid, 0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_overflow", s_ovf, 0);
    chk("clr_underflow", s_unf, 0);

    // thresholds
    chk("ae_at_0", s_ae, 1);
    for (int k = 1; k <= 14; k++) begin
      cyc(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0);
      if (k <= 2)  chk("ae_low", s_ae, 1);
      if (k == 3)  chk("ae_at_3", s_ae, 0);
      if (k == 13) chk("af_at_13", s_af, 0);
      if (k == 14) chk("af_at_14", s_af, 1);
    end
    cyc(1'b1, 16'h010F, 1'b0, 1'b0);
    cyc(1'b1, 16'h0110, 1'b0, 1'b0);

    // simultaneous access while full
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("full_both_ovf", s_ovf, 1);
    chk("full_both_dout", s_dout, 16'h0101);
    chk("full_both_count", s_count, 15);

    // err_clr, then err_clr coinciding with an overflowing write
    cyc(1'b1, 16'h0200, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("errclr_ovf", s_ovf, 0);
    cyc(1'b1, 16'h0300, 1'b0, 1'b1);
    chk("errclr_coincide_ovf", s_ovf, 1);

    // asynchronous reset mid-cycle
    #1 rst = 1'b1;
    #1;
    chk("async_count", s_count, 0);
    chk("async_empty", s_empty, 1);
    chk("async_full", s_full, 0);
    chk("async_ovf", s_ovf, 0);
    chk("async_af", s_af, 0);
    chk("async_f_count", f_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // simultaneous access while empty, then steady count 5 across pointer wrap
    cyc(1'b1, 16'h0055, 1'b1, 1'b0);
    chk("empty_both_count", s_count, 1);
    chk("empty_both_unf", s_unf, 1);
    for (int i = 1; i < 5; i++) cyc(1'b1, 16'h0055 + 16'(i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 16'h0060 + 16'(k), 1'b1, 1'b0);
      exp_d = (k < 5) ? 16'h0055 + 16'(k) : 16'h0060 + 16'(k - 5);
      chk("steady_count", s_count, 5);
      chk("steady_dout", s_dout, exp_d);
    end
    chk("steady_f_count", f_count, 5);

    // FWFT latency
    reset_pulse();
    cyc(1'b1, 16'hA5A5, 1'b0, 1'b0);
    chk("fwft_t_count", f_count, 1);
    chk("fwft_t_valid", f_valid, 0);
    chk("fwft_t_empty", f_empty, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fwft_t1_valid", f_valid, 1);
    chk("fwft_t1_dout", f_dout, 16'hA5A5);
    chk("fwft_t1_empty", f_empty, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("fwft_pop_count", f_count, 0);
    chk("fwft_pop_empty", f_empty, 1);

    // FWFT streaming, one word per clock
    cyc(1'b1, 16'h1000, 1'b0, 1'b0);
    cyc(1'b1, 16'h1001, 1'b0, 1'b0);
    for (int i = 2; i < 32; i++) begin
      cyc(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0);
      chk("stream_valid", f_valid, 1);
      chk("stream_dout", f_dout, 16'h1000 + 16'(i - 1));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_last_dout", f_dout, 16'h101F);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_end_count", f_count, 0);
    chk("stream_end_empty", f_empty, 1);
    chk("stream_end_unf", f_unf, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
